// File: rtl/alu16_pkg.sv
// Shared constants for the 16-bit registered ALU: opcode encodings,
// datapath width and status-flag bit positions.
package alu16_pkg;

    localparam int unsigned WIDTH = 16;

    // Status bit indices
    localparam int unsigned ZERO = 0;
    localparam int unsigned NEG  = 1;

    // Opcode encodings; 3'b101..3'b111 are illegal
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100
    } opcode_e;

endpackage : alu16_pkg

// File: rtl/alu16_comb.sv
// Combinational result and flag generation for alu16. An illegal opcode
// yields a zero result with both flags clear, so the zero flag is not
// raised for that case.
module alu16_comb
    import alu16_pkg::*;
(
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags
);

    logic legal;

    // Select the operation result; add/sub wrap modulo 2^16 with carry/borrow dropped
    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (opcode)
            OP_AND:  result = in0 & in1;
            OP_OR:   result = in0 | in1;
            OP_XOR:  result = in0 ^ in1;
            OP_ADD:  result = in0 + in1;
            OP_SUB:  result = in0 - in1;
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
    end

    // Derive zero/negative flags from the new result, only for legal opcodes
    always_comb begin
        flags       = '0;
        flags[ZERO] = legal && (result == '0);
        flags[NEG]  = legal && result[WIDTH-1];
    end

endmodule : alu16_comb

// File: rtl/alu16.sv
// 16-bit ALU with one cycle of latency: result and status flags are
// registered on every rising clock edge; asynchronous active-low reset.
module alu16
    import alu16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       status
);

    logic [WIDTH-1:0] result;
    logic [1:0]       flags;
    logic [WIDTH-1:0] out_d, out_q;
    logic [1:0]       status_d, status_q;

    alu16_comb u_comb (
        .opcode (opcode),
        .in0    (in0),
        .in1    (in1),
        .result (result),
        .flags  (flags)
    );

    // Next register values come straight from the combinational core
    always_comb begin
        out_d    = result;
        status_d = flags;
    end

    // Output/status registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            status_q <= '0;
        end else begin
            out_q    <= out_d;
            status_q <= status_d;
        end
    end

    assign out    = out_q;
    assign status = status_q;

endmodule : alu16

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: a behavioural reference model is compared
// against the DUT on every falling edge, plus hand-computed directed checks.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [2:0]  opcode;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [15:0] out;
    logic [1:0]  status;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [15:0] exp_out;
    logic [1:0]  exp_status;

    alu16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .in0    (in0),
        .in1    (in1),
        .out    (out),
        .status (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain arithmetic, {neg, zero, result}
    function automatic logic [17:0] model(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        int unsigned r;
        int unsigned ua;
        int unsigned ub;
        bit legal;
        logic [15:0] r16;
        ua = a;
        ub = b;
        legal = 1'b1;
        case (op)
            3'd0:    r = ua & ub;
            3'd1:    r = ua | ub;
            3'd2:    r = ua ^ ub;
            3'd3:    r = (ua + ub) % 65536;
            3'd4:    r = (ua + 65536 - ub) % 65536;
            default: begin r = 0; legal = 1'b0; end
        endcase
        r16 = r[15:0];
        return {legal && (r >= 32768), legal && (r == 0), r16};
    endfunction

    // Model state: loads on each rising edge, cleared at once by reset
    always @(posedge clk or negedge rst_n) begin
        logic [17:0] m;
        if (!rst_n) begin
            exp_out    = 16'h0000;
            exp_status = 2'b00;
        end else begin
            m = model(opcode, in0, in1);
            exp_out    = m[15:0];
            exp_status = m[17:16];
        end
    end

    // Continuous compare against the model on every falling edge
    always @(negedge clk) begin
        n_checks++;
        if (out !== exp_out) begin
            n_fails++;
            $display("FAIL model_out t=%0t got=%h exp=%h", $time, out, exp_out);
        end
        n_checks++;
        if (status !== exp_status) begin
            n_fails++;
            $display("FAIL model_status t=%0t got=%b exp=%b", $time, status, exp_status);
        end
        n_checks++;
        if (status === 2'b11) begin
            n_fails++;
            $display("FAIL flags_exclusive t=%0t got=%b exp=not 11", $time, status);
        end
    end

    task automatic check(input string name, input logic [15:0] got_o, input logic [1:0] got_s,
                         input logic [15:0] exp_o, input logic [1:0] exp_s);
        n_checks++;
        if (got_o !== exp_o || got_s !== exp_s) begin
            n_fails++;
            $display("FAIL %s got out=%h status=%b exp out=%h status=%b",
                     name, got_o, got_s, exp_o, exp_s);
        end
    endtask

    // Caller is at posedge+2; drive, wait one edge, check, return at posedge+2
    task automatic run_lit(input string name, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eo, input logic [1:0] es);
        opcode = op;
        in0    = a;
        in1    = b;
        @(posedge clk);
        #1;
        check(name, out, status, eo, es);
        #1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd3;
        in0    = 16'h1234;
        in1    = 16'h4321;
        #1;
        check("reset_state", out, status, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        check("reset_hold_edge", out, status, 16'h0000, 2'b00);
        #1;
        rst_n = 1'b1;

        run_lit("and",      3'b000, 16'h000F, 16'h0006, 16'h0006, 2'b00);
        run_lit("or",       3'b001, 16'h0008, 16'h0001, 16'h0009, 2'b00);
        run_lit("xor",      3'b010, 16'h000C, 16'h0006, 16'h000A, 2'b00);
        run_lit("add",      3'b011, 16'h000A, 16'h0003, 16'h000D, 2'b00);
        run_lit("add_wrap", 3'b011, 16'hFFFF, 16'h0002, 16'h0001, 2'b00);
        run_lit("sub",      3'b100, 16'h000C, 16'h000A, 16'h0002, 2'b00);
        run_lit("sub_neg",  3'b100, 16'h0000, 16'h0002, 16'hFFFE, 2'b10);
        run_lit("sub_zero", 3'b100, 16'h0005, 16'h0005, 16'h0000, 2'b01);
        run_lit("add_neg",  3'b011, 16'hFFFE, 16'h0000, 16'hFFFE, 2'b10);
        run_lit("illegal7", 3'b111, 16'hFFFE, 16'h0000, 16'h0000, 2'b00);
        run_lit("illegal5", 3'b101, 16'h0000, 16'h0000, 16'h0000, 2'b00);
        run_lit("illegal6", 3'b110, 16'h8000, 16'h0001, 16'h0000, 2'b00);

        // Latency: mid-cycle input change must not reach the outputs
        run_lit("lat_setup", 3'b011, 16'h0001, 16'h0001, 16'h0002, 2'b00);
        #3;
        opcode = 3'b010;
        in0    = 16'hFFFF;
        in1    = 16'h0000;
        #1;
        check("lat_midcycle", out, status, 16'h0002, 2'b00);
        @(posedge clk);
        #1;
        check("lat_after_edge", out, status, 16'hFFFF, 2'b10);
        #1;

        // Reset mid-operation
        run_lit("rst_setup", 3'b100, 16'h0000, 16'h0002, 16'hFFFE, 2'b10);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", out, status, 16'h0000, 2'b00);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_held", out, status, 16'h0000, 2'b00);
        end
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_release_pre_edge", out, status, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        check("rst_release_load", out, status, 16'hFFFE, 2'b10);
        #1;

        // Randomized traffic checked by the model on every falling edge
        for (int i = 0; i < 600; i++) begin
            opcode = 3'($urandom_range(0, 7));
            in0    = pick_operand();
            in1    = ($urandom_range(0, 7) == 0) ? in0 : pick_operand();
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                @(posedge clk);
                #2;
            end else begin
                @(posedge clk);
                #2;
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_alu16

// File: doc/alu16.md
ALU16 -- requirements
Module: alu16

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input and rst_n input.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  3  operation select, sampled on rising clk.
REQ-005 in0  input  16  first operand (minuend for SUB).
REQ-006 in1  input  16  second operand (subtrahend for SUB).
REQ-007 out  output  16  registered result.
REQ-008 status  output  2  registered flags: bit0 = zero, bit1 = negative.
REQ-009 Parameters: none; datapath width is fixed at 16 bits.

Function
REQ-010 Opcode map SHALL be: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB; 101/110/111 illegal.
REQ-011 AND/OR/XOR SHALL be bitwise on in0, in1.
REQ-012 ADD SHALL compute (in0 + in1) mod 2^16; carry-out discarded, no flag.
REQ-013 SUB SHALL compute (in0 - in1) mod 2^16; borrow discarded, no flag.
REQ-014 Operands SHALL be treated as raw 16-bit vectors; negative flag is interpretation of bit 15 only.
REQ-015 Latency SHALL be one cycle: opcode/in0/in1 present at rising edge N produce out/status valid after edge N, held until edge N+1.
REQ-016 out and status SHALL update on every rising edge (no enable, no handshake); stable inputs give stable outputs.
REQ-017 For legal opcodes, status[0] SHALL be 1 iff the new out value is 0x0000.
REQ-018 For legal opcodes, status[1] SHALL equal bit 15 of the new out value.
REQ-019 Zero and negative SHALL never both be 1.
REQ-020 Illegal opcode SHALL load out = 0x0000 and status = 2'b00 (zero flag deliberately not set).
REQ-021 Inputs between clock edges SHALL NOT affect outputs (no combinational path to out/status).

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) force out = 0x0000 and status = 2'b00.
REQ-023 While rst_n is low, clock edges SHALL NOT change outputs.
REQ-024 Reset asserted mid-operation SHALL discard the pending result; first rising edge after rst_n deasserts SHALL load the result of the inputs present at that edge.

Structure
REQ-025 A shared package alu16_pkg SHALL hold the opcode localparams (AND, OR, XOR, ADD, SUB), the width constant (16), and status bit indices (ZERO = 0, NEG = 1).
REQ-026 Combinational result/flag computation SHALL live in one sub-module alu16_comb; alu16 SHALL contain only the output/status registers and reset.

Verification
REQ-027 Logic: AND 0x000F,0x0006 -> 0x0006, status 00; OR 0x0008,0x0001 -> 0x0009; XOR 0x000C,0x0006 -> 0x000A, status 00.
REQ-028 ADD: 0x000A+0x0003 -> 0x000D, status 00; 0xFFFF+0x0002 -> 0x0001 (wrap), status 00.
REQ-029 SUB: 0x000C-0x000A -> 0x0002, status 00; 0x0000-0x0002 -> 0xFFFE, status 10; 0x0005-0x0005 -> 0x0000, status 01.
REQ-030 Negative: ADD 0xFFFE+0x0000 -> 0xFFFE, status 10; then opcode 111 -> out 0x0000, status 00.
REQ-031 Latency: change inputs mid-cycle -> out unchanged until next rising edge, correct immediately after it.
REQ-032 Reset: out = 0xFFFE, assert rst_n low between edges -> out 0x0000, status 00 at once; held through 2 edges; release -> next edge loads current result.
